// File: rtl/soc_pio_pkg.sv
// Shared constants for the input PIO: register map and edge-type codes.
package soc_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP  = 3'd3;
  localparam logic [2:0] ADDR_MASK_SET = 3'd4;
  localparam logic [2:0] ADDR_MASK_CLR = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser with previous-value register and edge event generation.
module pio_sync_edge
  import soc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_sync,
  output logic [WIDTH-1:0] evt
);

  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM_LOAD = AW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [AW-1:0]    arm_q, arm_d;
  logic [WIDTH-1:0] raw;

  assign data_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = data_sync;
    arm_d  = (arm_q == '0) ? arm_q : arm_q - AW'(1);
    raw    = data_sync & ~prev_q;
    case (EDGE_TYPE)
      EDGE_FALL: raw = ~data_sync & prev_q;
      EDGE_ANY:  raw = data_sync ^ prev_q;
      default:   raw = data_sync & ~prev_q;
    endcase
    // Hold off events until the chain and prev hold post-reset samples.
    evt = (arm_q == '0) ? raw : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
      arm_q  <= ARM_LOAD;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

endmodule

// File: rtl/soc_system_pio_in_capture.sv
// Avalon-MM input PIO: synchronised data, sticky edge capture, masked level irq.
module soc_system_pio_in_capture
  import soc_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int IRQ_EN      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic             wr_strobe;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             unused_wdata;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .in_port  (in_port),
    .data_sync(data_sync),
    .evt      (evt)
  );

  assign wr_strobe    = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_strobe) begin
      case (address)
        ADDR_IRQMASK:  mask_d = wdata;
        ADDR_MASK_SET: mask_d = mask_q | wdata;
        ADDR_MASK_CLR: mask_d = mask_q & ~wdata;
        ADDR_EDGECAP:  clr    = wdata;
        default: ;
      endcase
    end
    if (IRQ_EN == 0) begin
      mask_d = '0;
    end
    // New events are ORed in after the clear so a same-cycle set wins.
    cap_d = (cap_q & ~clr) | evt;
    rdata_d = '0;
    case (address)
      ADDR_DATA:    rdata_d = 32'(data_sync);
      ADDR_IRQMASK: rdata_d = 32'(mask_q);
      ADDR_EDGECAP: rdata_d = 32'(cap_q);
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q  <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = (IRQ_EN != 0) && (|(cap_q & mask_q));

endmodule
